// File: rtl/sram_uart_tx_interface.sv
// Streams a block of 16-bit SRAM words out of the UART TX pin, high byte first.
// Optional even parity bit per frame when TX_PARITY_EN is defined.
module sram_uart_tx_interface #(
    parameter int CLK_DIV      = 434,
    parameter int READ_LATENCY = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [17:0] Base_address,
    input  logic [17:0] Word_count,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic        UART_TX_O,
    output logic        Busy,
    output logic        Done,
    output logic [17:0] Words_sent
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LOAD,
        S_START_BIT,
        S_DATA_BIT,
`ifdef TX_PARITY_EN
        S_PARITY_BIT,
`endif
        S_STOP_BIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t      state, next_state;
    logic [17:0] address, remaining;
    logic [15:0] word;
    logic [7:0]  shreg, shreg_next;
    logic        byte_sel;
    logic [2:0]  bit_idx;
    logic [15:0] baud_cnt;
    logic [7:0]  wait_cnt;
    logic        bit_end, in_bit_state, tx_next;
`ifdef TX_PARITY_EN
    logic        parity;
`endif

    assign SRAM_we_n = 1'b1;

    always_ff @(posedge Clock) begin
        if (Reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state   = state;
        shreg_next   = shreg;
        tx_next      = 1'b1;
        bit_end      = (baud_cnt == 16'(CLK_DIV - 1));
        in_bit_state = (state == S_START_BIT) || (state == S_DATA_BIT) ||
`ifdef TX_PARITY_EN
                       (state == S_PARITY_BIT) ||
`endif
                       (state == S_STOP_BIT);
        case (state)
            S_IDLE:      if (Start) next_state = (Word_count == 18'd0) ? S_DONE : S_FETCH;
            S_FETCH:     next_state = (READ_LATENCY > 1) ? S_WAIT : S_LOAD;
            S_WAIT:      if (wait_cnt == 8'(READ_LATENCY - 2)) next_state = S_LOAD;
            S_LOAD:      next_state = S_START_BIT;
            S_START_BIT: begin
                shreg_next = byte_sel ? word[7:0] : word[15:8];
                if (bit_end) next_state = S_DATA_BIT;
            end
            S_DATA_BIT: begin
                if (bit_end) begin
                    shreg_next = shreg >> 1;
`ifdef TX_PARITY_EN
                    if (bit_idx == 3'd7) next_state = S_PARITY_BIT;
`else
                    if (bit_idx == 3'd7) next_state = S_STOP_BIT;
`endif
                end
            end
`ifdef TX_PARITY_EN
            S_PARITY_BIT: if (bit_end) next_state = S_STOP_BIT;
`endif
            S_STOP_BIT:  if (bit_end) next_state = byte_sel ? S_NEXT : S_START_BIT;
            S_NEXT:      next_state = (remaining == 18'd1) ? S_DONE : S_FETCH;
            S_DONE:      next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase

        // The line is registered from the upcoming state so it changes exactly on state entry.
        case (next_state)
            S_START_BIT:  tx_next = 1'b0;
            S_DATA_BIT:   tx_next = shreg_next[0];
`ifdef TX_PARITY_EN
            S_PARITY_BIT: tx_next = parity;
`endif
            default:      tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            UART_TX_O    <= 1'b1;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            SRAM_address <= 18'd0;
            Words_sent   <= 18'd0;
            address      <= 18'd0;
            remaining    <= 18'd0;
            word         <= 16'd0;
            shreg        <= 8'd0;
            byte_sel     <= 1'b0;
            bit_idx      <= 3'd0;
            baud_cnt     <= 16'd0;
            wait_cnt     <= 8'd0;
`ifdef TX_PARITY_EN
            parity       <= 1'b0;
`endif
        end else begin
            UART_TX_O <= tx_next;
            Busy      <= (next_state != S_IDLE) && (next_state != S_DONE);
            Done      <= (next_state == S_DONE);
            shreg     <= shreg_next;
            baud_cnt  <= (in_bit_state && !bit_end) ? baud_cnt + 16'd1 : 16'd0;
            wait_cnt  <= (state == S_WAIT) ? wait_cnt + 8'd1 : 8'd0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        address    <= Base_address;
                        remaining  <= Word_count;
                        Words_sent <= 18'd0;
                        if (Word_count != 18'd0) SRAM_address <= Base_address;
                    end
                end
                S_LOAD: begin
                    word     <= SRAM_read_data;
                    byte_sel <= 1'b0;
                end
                S_START_BIT: begin
                    bit_idx <= 3'd0;
`ifdef TX_PARITY_EN
                    parity  <= ^shreg_next;
`endif
                end
                S_DATA_BIT: if (bit_end) bit_idx <= bit_idx + 3'd1;
                S_STOP_BIT: if (bit_end && !byte_sel) byte_sel <= 1'b1;
                S_NEXT: begin
                    Words_sent <= Words_sent + 18'd1;
                    remaining  <= remaining - 18'd1;
                    address    <= address + 18'd1;
                    if (remaining != 18'd1) SRAM_address <= address + 18'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_uart_tx_interface.sv
// Self-checking bench for sram_uart_tx_interface: table-driven and random block
// transfers compared cycle-by-cycle against an expected serial waveform.
module tb_sram_uart_tx_interface;

    localparam int CLK_DIV      = 4;
    localparam int READ_LATENCY = 2;
`ifdef TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int WORD_CYCLES = 1 + READ_LATENCY + 2 * FRAME_BITS * CLK_DIV + 1;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [17:0] Base_address;
    logic [17:0] Word_count;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;
    logic        UART_TX_O;
    logic        Busy;
    logic        Done;
    logic [17:0] Words_sent;

    sram_uart_tx_interface #(.CLK_DIV(CLK_DIV), .READ_LATENCY(READ_LATENCY)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Start(Start),
        .Base_address(Base_address),
        .Word_count(Word_count),
        .SRAM_address(SRAM_address),
        .SRAM_we_n(SRAM_we_n),
        .SRAM_read_data(SRAM_read_data),
        .UART_TX_O(UART_TX_O),
        .Busy(Busy),
        .Done(Done),
        .Words_sent(Words_sent)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int          checkCount = 0;
    int          passCount  = 0;
    int unsigned memSalt;
    logic        expTx[$];

    typedef struct {
        logic [17:0] base;
        logic [17:0] count;
        int          expWords;
        int          expBusy;
        int          glitchAt;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [15:0] sramWord(input logic [17:0] a);
        case (a)
            18'h00100: return 16'hA55A;
            18'h00200: return 16'h0301;
            default:   return 16'(a * 18'd40503) ^ memSalt[15:0];
        endcase
    endfunction

    // SRAM controller model: data appears two cycles after the address.
    logic [15:0] rdPipe;
    always @(posedge Clock) begin
        rdPipe         <= sramWord(SRAM_address);
        SRAM_read_data <= rdPipe;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checkCount++;
        if (actual === required) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
    endtask

    task automatic buildExpected(input logic [17:0] base, input logic [17:0] count);
        logic [15:0] w;
        logic [7:0]  b;
        logic [17:0] a;
        expTx.delete();
        a = base;
        for (int n = 0; n < int'(count); n++) begin
            w = sramWord(a);
            repeat (READ_LATENCY + 1) expTx.push_back(1'b1);
            for (int h = 0; h < 2; h++) begin
                b = (h == 0) ? w[15:8] : w[7:0];
                repeat (CLK_DIV) expTx.push_back(1'b0);
                for (int i = 0; i < 8; i++) repeat (CLK_DIV) expTx.push_back(b[i]);
`ifdef TX_PARITY_EN
                repeat (CLK_DIV) expTx.push_back(^b);
`endif
                repeat (CLK_DIV) expTx.push_back(1'b1);
            end
            expTx.push_back(1'b1);
            a = a + 18'd1;
        end
        expTx.push_back(1'b1);
    endtask

    task automatic applyStimulus(input string name, input logic [17:0] base, input logic [17:0] count,
                                 input int expWords, input int expBusy, input int glitchAt);
        int          txErrs, busyCycles, doneCycle, doneCount;
        logic [17:0] addrBefore;
        txErrs = 0; busyCycles = 0; doneCycle = -1; doneCount = 0;
        buildExpected(base, count);
        addrBefore = SRAM_address;
        @(negedge Clock);
        Start = 1'b1; Base_address = base; Word_count = count;
        @(negedge Clock);
        Start = 1'b0; Base_address = 18'($urandom); Word_count = 18'($urandom);
        for (int i = 0; i < expTx.size(); i++) begin
            if (i > 0) @(negedge Clock);
            if (UART_TX_O !== expTx[i]) txErrs++;
            if (Busy === 1'b1) busyCycles++;
            if (Done === 1'b1) begin doneCount++; doneCycle = i; end
            Start = (i == glitchAt);
            if (i == glitchAt) begin
                Base_address = base ^ 18'h15555;
                Word_count   = 18'd2;
            end
        end
        @(negedge Clock);
        Start = 1'b0;
        if (Done === 1'b1) doneCount++;
        checkOutput({name, " tx mismatching cycles"}, txErrs, 0);
        checkOutput({name, " busy cycles"}, busyCycles, expBusy);
        checkOutput({name, " done cycle"}, doneCycle, expTx.size() - 1);
        checkOutput({name, " done pulse count"}, doneCount, 1);
        checkOutput({name, " words sent"}, Words_sent, expWords);
        checkOutput({name, " line idle after"}, {Busy, UART_TX_O}, 2'b01);
        if (count == 18'd0) checkOutput({name, " address unchanged"}, SRAM_address, addrBefore);
    endtask

    initial begin
        memSalt = $urandom;
        Reset = 1'b1; Start = 1'b0; Base_address = 18'd0; Word_count = 18'd0;

        vecs[0] = '{18'h00100, 18'd1, 1, WORD_CYCLES, -1};
        vecs[1] = '{18'h3FFFF, 18'd3, 3, 3 * WORD_CYCLES, -1};
        vecs[2] = '{18'h00010, 18'd0, 0, 0, -1};
        vecs[3] = '{18'h00200, 18'd1, 1, WORD_CYCLES, -1};
        vecs[4] = '{18'h2ABCD, 18'd2, 2, 2 * WORD_CYCLES, 40};

        repeat (3) @(negedge Clock);
        checkOutput("reset state", {UART_TX_O, Busy, Done, SRAM_we_n}, 4'b1001);
        checkOutput("reset address", SRAM_address, 18'd0);
        checkOutput("reset words sent", Words_sent, 18'd0);
        Reset = 1'b0;
        @(negedge Clock);

        for (int k = 0; k < 5; k++)
            applyStimulus($sformatf("vec%0d", k), vecs[k].base, vecs[k].count,
                          vecs[k].expWords, vecs[k].expBusy, vecs[k].glitchAt);

        for (int k = 0; k < 4; k++) begin
            logic [17:0] rb, rc;
            rb = 18'($urandom_range(0, 18'h3FFFF));
            rc = 18'($urandom_range(1, 3));
            applyStimulus($sformatf("rand%0d", k), rb, rc, int'(rc), int'(rc) * WORD_CYCLES, -1);
        end

        // Reset during data bit 3 of the first byte, then restart elsewhere.
        buildExpected(18'h00100, 18'd1);
        @(negedge Clock);
        Start = 1'b1; Base_address = 18'h00100; Word_count = 18'd1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (21) @(negedge Clock);
        checkOutput("pre-reset data bit 3", UART_TX_O, expTx[21]);
        checkOutput("pre-reset busy", Busy, 1'b1);
        Reset = 1'b1;
        @(negedge Clock);
        checkOutput("mid-frame reset line/busy/done", {UART_TX_O, Busy, Done}, 3'b100);
        checkOutput("mid-frame reset address", SRAM_address, 18'd0);
        Reset = 1'b0;
        applyStimulus("after reset", 18'h00200, 18'd1, 1, WORD_CYCLES, -1);

        checkOutput("we_n constant", SRAM_we_n, 1'b1);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
